spi_cmd_decode: RTL and testbench

//  Upstream stage of layer_code: turns the SPI slave byte stream into layer_code writes.

---
 rtl/spi_cmd_decode.sv | 154 +++++++++++++++
 tb/tb_spi_cmd_decode.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decode.sv
// SPI command decoder: turns a chip-select framed byte stream into timing register
// updates or pixel buffer byte writes, with a done pulse at the end of pixel frames.
module spi_cmd_decode #(
    parameter logic [7:0] CMD_CONF_WR  = 8'h2a,
    parameter logic [7:0] CMD_PIXEL_WR = 8'h2c,
    parameter logic [7:0] T0H_RST      = 8'h01,
    parameter logic [7:0] T0S_RST      = 8'h80,
    parameter logic [7:0] T1H_RST      = 8'h7f,
    parameter logic [7:0] T1S_RST      = 8'h80
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       spi_cs_n_in,
    input  logic       spi_byte_vld_in,
    input  logic [7:0] spi_byte_data_in,
    output logic       wr_en_out,
    output logic       wr_done_out,
    output logic [5:0] wr_addr_out,
    output logic [7:0] wr_data_out,
    output logic [3:0] wr_byte_en_out,
    output logic [7:0] t0h_cnt_out,
    output logic [7:0] t0s_cnt_out,
    output logic [7:0] t1h_cnt_out,
    output logic [7:0] t1s_cnt_out
);

    // state   | meaning
    // IDLE    | no transaction, waiting for cs_n falling edge
    // CMD     | cs_n low, waiting for the command byte
    // CONF    | collecting the four timing bytes into shadow registers
    // PIXEL   | each byte becomes a pixel buffer byte-lane write
    // DISCARD | ignore bytes until cs_n rises
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_CONF,
        S_PIXEL,
        S_DISCARD
    } state_t;

    state_t     state_q;
    logic       cs_prev_q;
    logic [1:0] conf_idx_q;
    logic [7:0] sh0_q, sh1_q, sh2_q;
    logic [7:0] pix_cnt_q;
    logic       pix_full_q;
    logic       pix_any_q;

    logic       wr_en_q, wr_done_q;
    logic [5:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [3:0] wr_be_q;
    logic [7:0] t0h_q, t0s_q, t1h_q, t1s_q;

    logic cs_fall, cs_rise, byte_take, take_cmd;

    assign cs_fall   = cs_prev_q & ~spi_cs_n_in;
    assign cs_rise   = ~cs_prev_q & spi_cs_n_in;
    assign byte_take = spi_byte_vld_in & ~spi_cs_n_in;
    // A byte arriving on the falling-edge cycle is already the command byte.
    assign take_cmd  = byte_take & ((state_q == S_IDLE && cs_fall) || state_q == S_CMD);

    // cs_prev_q resets low so a chip select held low through reset is not
    // mistaken for a new falling edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            cs_prev_q  <= 1'b0;
            conf_idx_q <= 2'd0;
            sh0_q      <= 8'h00;
            sh1_q      <= 8'h00;
            sh2_q      <= 8'h00;
            pix_cnt_q  <= 8'd0;
            pix_full_q <= 1'b0;
            pix_any_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_addr_q  <= 6'd0;
            wr_data_q  <= 8'h00;
            wr_be_q    <= 4'b0000;
            t0h_q      <= T0H_RST;
            t0s_q      <= T0S_RST;
            t1h_q      <= T1H_RST;
            t1s_q      <= T1S_RST;
        end else begin
            cs_prev_q <= spi_cs_n_in;
            wr_en_q   <= 1'b0;
            wr_done_q <= 1'b0;
            if (cs_rise) begin
                state_q   <= S_IDLE;
                wr_done_q <= (state_q == S_PIXEL) && pix_any_q;
            end else if (take_cmd) begin
                if (spi_byte_data_in == CMD_CONF_WR) begin
                    state_q    <= S_CONF;
                    conf_idx_q <= 2'd0;
                end else if (spi_byte_data_in == CMD_PIXEL_WR) begin
                    state_q    <= S_PIXEL;
                    pix_cnt_q  <= 8'd0;
                    pix_full_q <= 1'b0;
                    pix_any_q  <= 1'b0;
                end else begin
                    state_q <= S_DISCARD;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cs_fall) state_q <= S_CMD;
                    end
                    S_CONF: begin
                        if (byte_take) begin
                            conf_idx_q <= conf_idx_q + 2'd1;
                            case (conf_idx_q)
                                2'd0: sh0_q <= spi_byte_data_in;
                                2'd1: sh1_q <= spi_byte_data_in;
                                2'd2: sh2_q <= spi_byte_data_in;
                                default: begin
                                    t0h_q   <= sh0_q;
                                    t0s_q   <= sh1_q;
                                    t1h_q   <= sh2_q;
                                    t1s_q   <= spi_byte_data_in;
                                    state_q <= S_DISCARD;
                                end
                            endcase
                        end
                    end
                    S_PIXEL: begin
                        if (byte_take && !pix_full_q) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= pix_cnt_q[7:2];
                            wr_be_q   <= 4'b1000 >> pix_cnt_q[1:0];
                            wr_data_q <= spi_byte_data_in;
                            pix_any_q <= 1'b1;
                            // Saturate at the last lane of word 63 rather than wrapping.
                            if (pix_cnt_q == 8'hff) pix_full_q <= 1'b1;
                            else                    pix_cnt_q  <= pix_cnt_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en_out      = wr_en_q;
    assign wr_done_out    = wr_done_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign wr_byte_en_out = wr_be_q;
    assign t0h_cnt_out    = t0h_q;
    assign t0s_cnt_out    = t0s_q;
    assign t1h_cnt_out    = t1h_q;
    assign t1s_cnt_out    = t1s_q;

endmodule

// File: tb/tb_spi_cmd_decode.sv
// Directed testbench for spi_cmd_decode: configuration writes, pixel writes,
// saturation, aborted transactions and asynchronous reset.
module tb_spi_cmd_decode;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       spi_cs_n_in = 1'b1;
    logic       spi_byte_vld_in = 1'b0;
    logic [7:0] spi_byte_data_in = 8'h00;
    logic       wr_en_out, wr_done_out;
    logic [5:0] wr_addr_out;
    logic [7:0] wr_data_out;
    logic [3:0] wr_byte_en_out;
    logic [7:0] t0h_cnt_out, t0s_cnt_out, t1h_cnt_out, t1s_cnt_out;

    int checks = 0;
    int errors = 0;

    spi_cmd_decode dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .spi_cs_n_in     (spi_cs_n_in),
        .spi_byte_vld_in (spi_byte_vld_in),
        .spi_byte_data_in(spi_byte_data_in),
        .wr_en_out       (wr_en_out),
        .wr_done_out     (wr_done_out),
        .wr_addr_out     (wr_addr_out),
        .wr_data_out     (wr_data_out),
        .wr_byte_en_out  (wr_byte_en_out),
        .t0h_cnt_out     (t0h_cnt_out),
        .t0s_cnt_out     (t0s_cnt_out),
        .t1h_cnt_out     (t1h_cnt_out),
        .t1s_cnt_out     (t1s_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] timing();
        return {t0h_cnt_out, t0s_cnt_out, t1h_cnt_out, t1s_cnt_out};
    endfunction

    // Byte strobe for one cycle; on return outputs reflect that byte.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_in);
        spi_byte_vld_in  = 1'b1;
        spi_byte_data_in = b;
        @(negedge clk_in);
        spi_byte_vld_in  = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [5:0] addr,
                          input logic [3:0] be, input logic [7:0] data);
        chk({tag, ".en"}, {31'd0, wr_en_out}, {31'd0, en});
        if (en) begin
            chk({tag, ".addr"}, {26'd0, wr_addr_out}, {26'd0, addr});
            chk({tag, ".be"}, {28'd0, wr_byte_en_out}, {28'd0, be});
            chk({tag, ".data"}, {24'd0, wr_data_out}, {24'd0, data});
        end
    endtask

    task automatic cs_low();
        @(negedge clk_in);
        spi_cs_n_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic cs_high_chk(input string tag, input logic exp_done);
        @(negedge clk_in);
        spi_cs_n_in = 1'b1;
        @(negedge clk_in);
        chk({tag, ".done"}, {31'd0, wr_done_out}, {31'd0, exp_done});
        @(negedge clk_in);
        chk({tag, ".done_off"}, {31'd0, wr_done_out}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [3:0] be_exp;
        int         n_wr;

        // 1: reset values
        repeat (2) @(negedge clk_in);
        chk("rst.timing", timing(), 32'h01807f80);
        chk("rst.wr", {30'd0, wr_en_out, wr_done_out}, 32'd0);
        chk("rst.addr", {18'd0, wr_addr_out, wr_data_out}, 32'd0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // 2: full configuration write
        cs_low();
        send_byte(8'h2a);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        chk("conf.pre", timing(), 32'h01807f80);
        send_byte(8'h40);
        chk("conf.commit", timing(), 32'h10203040);
        chk("conf.no_wr", {31'd0, wr_en_out}, 32'd0);
        send_byte(8'h99);
        chk("conf.discard", timing(), 32'h10203040);
        cs_high_chk("conf", 1'b0);

        // 3: truncated configuration leaves timing untouched
        cs_low();
        send_byte(8'h2a);
        send_byte(8'h55);
        send_byte(8'h66);
        cs_high_chk("conf_short", 1'b0);
        chk("conf_short.timing", timing(), 32'h10203040);

        // 4: four-byte pixel write
        cs_low();
        send_byte(8'h2c);
        chk("px4.cmd", {31'd0, wr_en_out}, 32'd0);
        send_byte(8'h01); chk_wr("px4.b0", 1'b1, 6'd0, 4'b1000, 8'h01);
        send_byte(8'h00); chk_wr("px4.b1", 1'b1, 6'd0, 4'b0100, 8'h00);
        send_byte(8'h00); chk_wr("px4.b2", 1'b1, 6'd0, 4'b0010, 8'h00);
        send_byte(8'hff); chk_wr("px4.b3", 1'b1, 6'd0, 4'b0001, 8'hff);
        @(negedge clk_in);
        chk_wr("px4.idle", 1'b0, 6'd0, 4'b0001, 8'hff);
        chk("px4.hold", {18'd0, wr_addr_out, wr_data_out}, {18'd0, 6'd0, 8'hff});
        cs_high_chk("px4", 1'b1);

        // 5: 260 payload bytes, counter saturates after 256
        n_wr = 0;
        cs_low();
        send_byte(8'h2c);
        for (int k = 0; k < 260; k++) begin
            b = k[7:0] ^ 8'h3c;
            be_exp = 4'b1000 >> k[1:0];
            send_byte(b);
            if (wr_en_out) n_wr++;
            chk_wr("px5", (k < 256), k[7:2], be_exp, b);
        end
        chk("px5.count", n_wr, 32'd256);
        chk("px5.last", {22'd0, wr_addr_out, wr_byte_en_out}, {22'd0, 6'd63, 4'b0001});
        cs_high_chk("px5", 1'b1);

        // 6a: unknown opcode
        cs_low();
        send_byte(8'h5a);
        send_byte(8'h01); chk("bad.b1", {31'd0, wr_en_out}, 32'd0);
        send_byte(8'h02); chk("bad.b2", {31'd0, wr_en_out}, 32'd0);
        cs_high_chk("bad", 1'b0);

        // 6b: pixel opcode with no payload
        cs_low();
        send_byte(8'h2c);
        cs_high_chk("px_empty", 1'b0);

        // Command byte on the falling-edge cycle; payload byte on the rising-edge cycle
        @(negedge clk_in);
        spi_cs_n_in = 1'b0;
        spi_byte_vld_in = 1'b1;
        spi_byte_data_in = 8'h2c;
        @(negedge clk_in);
        spi_byte_vld_in = 1'b0;
        send_byte(8'h5e); chk_wr("sim.b0", 1'b1, 6'd0, 4'b1000, 8'h5e);
        @(negedge clk_in);
        spi_cs_n_in = 1'b1;
        spi_byte_vld_in = 1'b1;
        spi_byte_data_in = 8'h77;
        @(negedge clk_in);
        spi_byte_vld_in = 1'b0;
        chk("sim.edge_byte", {31'd0, wr_en_out}, 32'd0);
        chk("sim.done", {31'd0, wr_done_out}, 32'd1);
        @(negedge clk_in);
        chk("sim.done_off", {31'd0, wr_done_out}, 32'd0);

        // 6c: reset during a pixel transaction
        cs_low();
        send_byte(8'h2c);
        send_byte(8'h11); chk_wr("rst_px.b0", 1'b1, 6'd0, 4'b1000, 8'h11);
        send_byte(8'h22); chk_wr("rst_px.b1", 1'b1, 6'd0, 4'b0100, 8'h22);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("rst_px.wr", {30'd0, wr_en_out, wr_done_out}, 32'd0);
        chk("rst_px.addr", {14'd0, wr_addr_out, wr_data_out, wr_byte_en_out}, 32'd0);
        chk("rst_px.timing", timing(), 32'h01807f80);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        send_byte(8'h2c);
        send_byte(8'h33); chk("rst_px.no_decode", {31'd0, wr_en_out}, 32'd0);
        cs_high_chk("rst_px", 1'b0);
        cs_low();
        send_byte(8'h2c);
        send_byte(8'haa); chk_wr("rst_px.resume", 1'b1, 6'd0, 4'b1000, 8'haa);
        cs_high_chk("rst_px.resume", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
